branch_predictor: RTL

//  Fetch-stage direct-mapped BTB with 2-bit saturating counters. Produces predicted_takenF /

---
 rtl/bp_pkg.sv | 31 +++
 rtl/bp_sat_counter.sv | 15 +
 rtl/branch_predictor.sv | 131 +++++++++++++
 3 files changed

// File: rtl/bp_pkg.sv
// Shared types and helpers for the fetch-stage branch predictor.
//   ctr_t       2-bit saturating direction counter (SNT, WNT, WT, ST)
//   CTR_RESET   counter value every entry holds after reset
//   CTR_ALLOC   counter value of a freshly allocated entry
//   sat_update  next counter value given the resolved direction
package bp_pkg;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_t;

  localparam ctr_t CTR_RESET = WNT;
  localparam ctr_t CTR_ALLOC = WT;

  // Increment towards ST on taken, decrement towards SNT on not-taken,
  // holding at either end.
  function automatic ctr_t sat_update(ctr_t cur, logic taken);
    ctr_t nxt;
    nxt = cur;
    if (taken) begin
      if (cur != ST) nxt = ctr_t'(cur + 2'd1);
    end else begin
      if (cur != SNT) nxt = ctr_t'(cur - 2'd1);
    end
    return nxt;
  endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// Combinational next-state for one 2-bit saturating direction counter.
//   ctrCur   in  2  current counter value
//   taken    in  1  resolved branch direction
//   ctrNext  out 2  counter value after training with 'taken'
module bp_sat_counter
  import bp_pkg::*;
(
  input  logic [1:0] ctrCur,
  input  logic       taken,
  output logic [1:0] ctrNext
);

  assign ctrNext = sat_update(ctr_t'(ctrCur), taken);

endmodule

// File: rtl/branch_predictor.sv
// Fetch-stage direct-mapped BTB with 2-bit saturating direction counters.
// Lookup is combinational on PCF; training happens on the rising edge when a
// branch resolves in Execute. A lookup and an update to the same index in the
// same cycle see the pre-update entry (the arrays are only written at the edge).
//
// Optional feature: define BP_PERF_CNT_EN to add the BranchCount and
// MispredictCount statistics counters and their ports.
//
// Ports:
//   clk                in   1   clock
//   reset              in   1   synchronous, active-high
//   PCF                in   32  fetch PC
//   predicted_takenF   out  1   BTB hit and counter says taken
//   predicted_targetF  out  32  stored target when predicted taken, else PCF+4
//   BranchResolvedE    in   1   update strobe from Execute
//   PCE                in   32  PC of the resolving branch
//   PCSrcE             in   1   actual direction (1 = taken)
//   PCTargetE          in   32  actual target
//   BranchCount        out  32  resolved-branch count (BP_PERF_CNT_EN)
//   MispredictCount    out  32  mispredict count (BP_PERF_CNT_EN)
//   MispredictE        in   1   mispredict flag from flush_unit (statistics only)
module branch_predictor
  import bp_pkg::*;
#(
  parameter int ENTRIES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] PCF,
  output logic        predicted_takenF,
  output logic [31:0] predicted_targetF,
  input  logic        BranchResolvedE,
  input  logic [31:0] PCE,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
`ifdef BP_PERF_CNT_EN
  output logic [31:0] BranchCount,
  output logic [31:0] MispredictCount,
`endif
  input  logic        MispredictE
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = 30 - IDX_W;

  // Storage: valid and counter need a defined reset value; tag and target
  // are only meaningful behind valid, so they are left without reset.
  logic             validArr  [ENTRIES];
  ctr_t             ctrArr    [ENTRIES];
  logic [TAG_W-1:0] tagArr    [ENTRIES];
  logic [31:0]      targetArr [ENTRIES];

  // Fetch lookup.
  logic [IDX_W-1:0] idxF;
  logic [TAG_W-1:0] tagF;
  logic             hitF;

  assign idxF = PCF[IDX_W+1:2];
  assign tagF = PCF[31:IDX_W+2];
  assign hitF = validArr[idxF] && (tagArr[idxF] == tagF);

  // Gated by reset so the reset cycle itself already predicts fall-through,
  // before the cleared valid bits become visible.
  assign predicted_takenF  = !reset && hitF && ctrArr[idxF][1];
  assign predicted_targetF = predicted_takenF ? targetArr[idxF] : (PCF + 32'd4);

  // Execute update path.
  logic [IDX_W-1:0] idxE;
  logic [TAG_W-1:0] tagE;
  logic             hitE;
  logic [1:0]       ctrNextE;

  assign idxE = PCE[IDX_W+1:2];
  assign tagE = PCE[31:IDX_W+2];
  assign hitE = validArr[idxE] && (tagArr[idxE] == tagE);

  bp_sat_counter uSatCounter (
    .ctrCur  (ctrArr[idxE]),
    .taken   (PCSrcE),
    .ctrNext (ctrNextE)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        validArr[i] <= 1'b0;
        ctrArr[i]   <= CTR_RESET;
      end
    end else if (BranchResolvedE) begin
      if (hitE) begin
        ctrArr[idxE] <= ctr_t'(ctrNextE);
      end else if (PCSrcE) begin
        // Only taken branches earn an entry; a not-taken miss would just
        // evict something useful to predict fall-through again.
        validArr[idxE] <= 1'b1;
        ctrArr[idxE]   <= CTR_ALLOC;
      end
    end
  end

  // Taken resolution writes tag and target for both a hit (refreshing a
  // possibly changed indirect target) and an allocation; the tag rewrite on
  // a hit is harmless since it is unchanged.
  always_ff @(posedge clk) begin
    if (!reset && BranchResolvedE && PCSrcE) begin
      tagArr[idxE]    <= tagE;
      targetArr[idxE] <= PCTargetE;
    end
  end

`ifdef BP_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      BranchCount     <= 32'd0;
      MispredictCount <= 32'd0;
    end else if (BranchResolvedE) begin
      BranchCount <= BranchCount + 32'd1;
      if (MispredictE) MispredictCount <= MispredictCount + 32'd1;
    end
  end

  logic unusedBits;
  assign unusedBits = ^{PCF[1:0], PCE[1:0]};
`else
  // Instruction PCs are word aligned and the mispredict flag only feeds the
  // optional statistics.
  logic unusedBits;
  assign unusedBits = ^{PCF[1:0], PCE[1:0], MispredictE};
`endif

endmodule
